// File: rtl/memory_controller.sv
// memory_controller: byte-serial RAM arbiter for LSB loads/stores and icache word fetches.
// Define MC_IO_STALL_EN to hold IO-window store bytes while io_buffer_full and pad each with an idle cycle.
module memory_controller #(
  parameter int ADDR_W = 32,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              lsb_to_mc_ready,
  input  logic [1:0]        lsb_to_mc_len,
  input  logic              lsb_to_mc_opType,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [31:0]       lsb_to_mc_data,
  output logic              mc_to_lsb_valid,
  output logic              mc_to_lsb_ld_done,
  output logic              mc_to_lsb_st_done,
  output logic [31:0]       mc_to_lsb_result,
  input  logic              icache_to_mc_ready,
  input  logic [ADDR_W-1:0] icache_to_mc_addr,
  output logic              mc_to_icache_done,
  output logic [31:0]       mc_to_icache_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;
  state_t state, state_d;
  logic [2:0] k, n, nk, n_req;
  logic [ADDR_W-1:0] base;
  logic [31:0] data, acc, rd_word;
  logic wr_q, gap, stall, gap_need, rd_last, st_last, accept;
  assign nk = k + 3'd1;
  assign n_req = lsb_to_mc_len == 2'b11 ? 3'd4 : lsb_to_mc_len == 2'b10 ? 3'd2 : 3'd1;
  assign rd_last = k == n;
  assign st_last = k == n - 3'd1;
  assign accept = lsb_to_mc_ready || (icache_to_mc_ready && !clr_in);
  // k counts presented addresses; the byte on mem_din belongs to lane k-1
  assign rd_word = acc | ({24'b0, mem_din} << {k - 3'd1, 3'b000});
`ifdef MC_IO_STALL_EN
  assign gap_need = mem_a[17:16] == IO_HI;
  assign stall = gap_need && io_buffer_full && !gap;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign gap_need = 1'b0;
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (rdy_in)
      case (state)
        IDLE:  state_d = lsb_to_mc_ready ? (lsb_to_mc_opType ? STORE : LOAD) : accept ? FETCH : IDLE;
        LOAD:  state_d = rd_last ? IDLE : LOAD;
        FETCH: state_d = (rd_last || clr_in) ? IDLE : FETCH;
        STORE: state_d = (st_last && !gap && !stall) ? IDLE : STORE;
      endcase
  end
  always_comb mem_wr = wr_q && rdy_in && !stall;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      k <= '0;
      n <= '0;
      base <= '0;
      data <= '0;
      acc <= '0;
      wr_q <= 1'b0;
      gap <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      mc_to_lsb_valid <= 1'b0;
      mc_to_lsb_ld_done <= 1'b0;
      mc_to_lsb_st_done <= 1'b0;
      mc_to_lsb_result <= '0;
      mc_to_icache_done <= 1'b0;
      mc_to_icache_data <= '0;
    end else begin
      mc_to_lsb_valid <= 1'b0;
      mc_to_lsb_ld_done <= 1'b0;
      mc_to_lsb_st_done <= 1'b0;
      mc_to_icache_done <= 1'b0;
      if (rdy_in)
        case (state)
          IDLE: if (accept) begin
            base <= lsb_to_mc_ready ? lsb_to_mc_addr : icache_to_mc_addr;
            mem_a <= lsb_to_mc_ready ? lsb_to_mc_addr : icache_to_mc_addr;
            n <= lsb_to_mc_ready ? n_req : 3'd4;
            k <= '0;
            acc <= '0;
            gap <= 1'b0;
            data <= lsb_to_mc_data;
            mem_dout <= lsb_to_mc_data[7:0];
            wr_q <= lsb_to_mc_ready && lsb_to_mc_opType;
            mc_to_lsb_valid <= lsb_to_mc_ready;
          end
          LOAD, FETCH: if (!(state == FETCH && clr_in)) begin
            k <= nk;
            if (k != 3'd0) acc[{k - 3'd1, 3'b000} +: 8] <= mem_din;
            if (nk < n) mem_a <= base + ADDR_W'(nk);
            if (rd_last && state == LOAD) begin
              mc_to_lsb_result <= rd_word;
              mc_to_lsb_ld_done <= 1'b1;
            end
            if (rd_last && state == FETCH) begin
              mc_to_icache_data <= rd_word;
              mc_to_icache_done <= 1'b1;
            end
          end
          STORE: if (gap) begin
            gap <= 1'b0;
            wr_q <= 1'b1;
          end else if (!stall) begin
            if (st_last) begin
              wr_q <= 1'b0;
              mc_to_lsb_st_done <= 1'b1;
            end else begin
              k <= nk;
              gap <= gap_need;
              wr_q <= !gap_need;
              mem_a <= base + ADDR_W'(nk);
              mem_dout <= data[{nk, 3'b000} +: 8];
            end
          end
        endcase
    end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: random and directed traffic checked cycle-by-cycle against a schedule model.
module tb_memory_controller;
  logic clk = 0, rst = 1, rdy = 1, clr = 0;
  logic lsb_ready = 0, lsb_op = 0, ic_ready = 0, io_full = 0;
  logic [1:0] lsb_len = 0;
  logic [31:0] lsb_addr = 0, lsb_data = 0, ic_addr = 0;
  logic mc_to_lsb_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_icache_done, mem_wr;
  logic [31:0] mc_to_lsb_result, mc_to_icache_data, mem_a;
  logic [7:0] mem_din = 0, mem_dout;
  int cyc = 0, errors = 0, checks = 0, free_at = 0;
  logic [7:0] ram [1024];
  logic [7:0] mdl [1024];
  bit e_valid [int];
  bit e_st [int];
  logic [31:0] e_ld [int];
  logic [31:0] e_ic [int];
  logic [31:0] e_a [int];
  logic [7:0] e_w [int];

  memory_controller dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr),
    .lsb_to_mc_ready(lsb_ready), .lsb_to_mc_len(lsb_len), .lsb_to_mc_opType(lsb_op),
    .lsb_to_mc_addr(lsb_addr), .lsb_to_mc_data(lsb_data),
    .mc_to_lsb_valid(mc_to_lsb_valid), .mc_to_lsb_ld_done(mc_to_lsb_ld_done),
    .mc_to_lsb_st_done(mc_to_lsb_st_done), .mc_to_lsb_result(mc_to_lsb_result),
    .icache_to_mc_ready(ic_ready), .icache_to_mc_addr(ic_addr),
    .mc_to_icache_done(mc_to_icache_done), .mc_to_icache_data(mc_to_icache_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // 1 KiB RAM aliased over the whole address space; read data lags the address by one cycle
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) if (!rst) begin
    chk("valid", 32'(mc_to_lsb_valid), 32'(e_valid.exists(cyc)));
    chk("ld_done", 32'(mc_to_lsb_ld_done), 32'(e_ld.exists(cyc)));
    chk("st_done", 32'(mc_to_lsb_st_done), 32'(e_st.exists(cyc)));
    chk("ic_done", 32'(mc_to_icache_done), 32'(e_ic.exists(cyc)));
    chk("mem_wr", 32'(mem_wr), 32'(e_w.exists(cyc)));
    if (e_a.exists(cyc)) chk("mem_a", mem_a, e_a[cyc]);
    if (e_w.exists(cyc)) chk("mem_dout", 32'(mem_dout), 32'(e_w[cyc]));
    if (e_ld.exists(cyc)) chk("ld_result", mc_to_lsb_result, e_ld[cyc]);
    if (e_ic.exists(cyc)) chk("ic_data", mc_to_icache_data, e_ic[cyc]);
  end

  function automatic void sched_lsb(input int a, input bit op, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] data);
    int n = len == 2'b11 ? 4 : len == 2'b10 ? 2 : 1;
    logic [31:0] w = 0;
    logic [31:0] ad;
    e_valid[a + 1] = 1;
    for (int j = 0; j < n; j++) begin
      ad = addr + 32'(j);
      e_a[a + 1 + j] = ad;
      if (op) begin
        e_w[a + 1 + j] = data[8*j +: 8];
        mdl[ad[9:0]] = data[8*j +: 8];
      end else w[8*j +: 8] = mdl[ad[9:0]];
    end
    if (op) e_st[a + n + 1] = 1;
    else e_ld[a + n + 2] = w;
    free_at = op ? a + n + 1 : a + n + 2;
  endfunction

  function automatic void sched_fetch(input int a, input logic [31:0] addr);
    logic [31:0] w = 0;
    logic [31:0] ad;
    for (int j = 0; j < 4; j++) begin
      ad = addr + 32'(j);
      e_a[a + 1 + j] = ad;
      w[8*j +: 8] = mdl[ad[9:0]];
    end
    e_ic[a + 6] = w;
    free_at = a + 6;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic lsb_req(input bit op, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] data, output int a);
    a = cyc > free_at ? cyc : free_at;
    lsb_ready = 1;
    lsb_op = op;
    lsb_len = len;
    lsb_addr = addr;
    lsb_data = data;
    sched_lsb(a, op, len, addr, data);
    wait_to(a + 1);
    lsb_ready = 0;
    lsb_data = $urandom;
  endtask

  task automatic fetch_req(input logic [31:0] addr, output int a);
    a = cyc > free_at ? cyc : free_at;
    ic_ready = 1;
    ic_addr = addr;
    sched_fetch(a, addr);
    wait_to(a + 1);
    ic_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, c, t;
    logic [31:0] ad;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i * 37 + 5);
      mdl[i] = 8'(i * 37 + 5);
    end
    for (int i = 0; i < 4; i++) begin
      ram[256 + i] = 8'h11 * 8'(i + 1);
      mdl[256 + i] = 8'h11 * 8'(i + 1);
    end
    ram[10'h202] = 8'h77;
    mdl[10'h202] = 8'h77;
    #12;
    chk("rst_valid", 32'(mc_to_lsb_valid), 0);
    chk("rst_ld_done", 32'(mc_to_lsb_ld_done), 0);
    chk("rst_st_done", 32'(mc_to_lsb_st_done), 0);
    chk("rst_ic_done", 32'(mc_to_icache_done), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_result", mc_to_lsb_result, 0);
    chk("rst_ic_data", mc_to_icache_data, 0);
    step();
    rst = 0;
    free_at = cyc;
    // LW of known bytes
    lsb_req(0, 2'b11, 32'h100, 0, a);
    wait_to(a + 6);
    #3;
    chk("lw_done_lit", 32'(mc_to_lsb_ld_done), 1);
    chk("lw_result_lit", mc_to_lsb_result, 32'h44332211);
    // SH writes only two bytes
    lsb_req(1, 2'b10, 32'h200, 32'hDEADBEEF, a);
    wait_to(a + 4);
    chk("sh_b0_lit", 32'(ram[10'h200]), 32'hEF);
    chk("sh_b1_lit", 32'(ram[10'h201]), 32'hBE);
    chk("sh_b2_lit", 32'(ram[10'h202]), 32'h77);
    // simultaneous LB and fetch: LB first, fetch waits
    wait_to(free_at);
    c = cyc;
    lsb_ready = 1; lsb_op = 0; lsb_len = 2'b01; lsb_addr = 32'h10;
    ic_ready = 1; ic_addr = 0;
    sched_lsb(c, 0, 2'b01, 32'h10, 0);
    sched_fetch(free_at, 0);
    wait_to(c + 1);
    lsb_ready = 0;
    wait_to(c + 3);
    #3;
    chk("lb_zext_lit", mc_to_lsb_result[31:8], 0);
    wait_to(c + 4);
    ic_ready = 0;
    // fetch flushed in its third cycle, then an immediate LSB request
    wait_to(free_at);
    a = cyc;
    ic_ready = 1;
    ic_addr = 32'h40;
    for (int j = 0; j < 3; j++) e_a[a + 1 + j] = 32'h40 + 32'(j);
    wait_to(a + 1);
    ic_ready = 0;
    wait_to(a + 3);
    clr = 1;
    step();
    clr = 0;
    free_at = a + 4;
    lsb_req(0, 2'b11, 32'h40, 0, a);
    // SW still completes under flush
    lsb_req(1, 2'b11, 32'h80, 32'hCAFEF00D, a);
    clr = 1;
    repeat (3) step();
    clr = 0;
    // rdy low blocks acceptance
    wait_to(free_at);
    rdy = 0;
    lsb_ready = 1; lsb_op = 0; lsb_len = 2'b11; lsb_addr = 32'h80;
    repeat (4) step();
    rdy = 1;
    a = cyc;
    sched_lsb(a, 0, 2'b11, 32'h80, 0);
    wait_to(a + 1);
    lsb_ready = 0;
    // wrapping load
    lsb_req(0, 2'b11, 32'hFFFFFFFE, 0, a);
`ifdef MC_IO_STALL_EN
    wait_to(free_at);
    a = cyc;
    io_full = 1;
    lsb_ready = 1; lsb_op = 1; lsb_len = 2'b01; lsb_addr = 32'h30000; lsb_data = 32'hA5;
    e_valid[a + 1] = 1;
    for (int j = 1; j <= 6; j++) e_a[a + j] = 32'h30000;
    e_w[a + 6] = 8'hA5;
    e_st[a + 7] = 1;
    mdl[0] = 8'hA5;
    free_at = a + 7;
    wait_to(a + 1);
    lsb_ready = 0;
    wait_to(a + 6);
    io_full = 0;
`else
    io_full = 1;
    lsb_req(1, 2'b01, 32'h30000, 32'hA5, a);
    wait_to(free_at);
    io_full = 0;
`endif
    // randomized mixed traffic
    repeat (60) begin
      wait_to(free_at - 2 + int'($urandom_range(0, 3)));
      t = int'($urandom_range(0, 6));
      ad = 32'($urandom_range(0, 511));
      if (!(t >= 3 && t < 6) && $urandom_range(0, 5) == 0) ad = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      if (t == 6) fetch_req(ad, a);
      else lsb_req(t >= 3, 2'($urandom_range(0, 3)), ad, $urandom, a);
    end
    // asynchronous reset in the middle of a load
    lsb_req(0, 2'b11, 32'h141, 0, a);
    step();
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 32'(mc_to_lsb_valid), 0);
    chk("arst_ld_done", 32'(mc_to_lsb_ld_done), 0);
    chk("arst_mem_wr", 32'(mem_wr), 0);
    chk("arst_mem_a", mem_a, 0);
    chk("arst_mem_dout", 32'(mem_dout), 0);
    chk("arst_result", mc_to_lsb_result, 0);
    chk("arst_ic_data", mc_to_icache_data, 0);
    e_valid.delete(); e_st.delete(); e_ld.delete(); e_ic.delete(); e_a.delete(); e_w.delete();
    step();
    rst = 0;
    free_at = cyc;
    lsb_req(0, 2'b11, 32'h100, 0, a);
    fetch_req(32'h200, a);
    wait_to(free_at + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
